// File: rtl/restoring_div_n.sv
// restoring_div_n: WIDTH-bit restoring divider, one quotient bit per clock, start/ready/valid handshake.
// Define RESTORING_DIV_SIGNED_EN for two's-complement operands (adds the FIX sign-correction state).
module restoring_div_n #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             dbz
);
    localparam int CW = $clog2(WIDTH) + 1;
`ifdef RESTORING_DIV_SIGNED_EN
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    logic neg_q_q, neg_q_d, neg_r_q, neg_r_d;
    logic [WIDTH-1:0] a_mag, b_mag;
    assign a_mag = dividend[WIDTH-1] ? -dividend : dividend;
    assign b_mag = divisor[WIDTH-1] ? -divisor : divisor;
`else
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    logic [WIDTH-1:0] a_mag, b_mag;
    assign a_mag = dividend;
    assign b_mag = divisor;
`endif
    state_t           state_q, state_d;
    logic [WIDTH:0]   r_q, r_d, sh, trial;
    logic [WIDTH-1:0] q_q, q_d, d_q, d_d, quot_q, quot_d, rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dz_q, dz_d, dbz_q, dbz_d;

    // partial remainder never exceeds the divisor, so dropping R's MSB on the shift loses nothing
    assign sh    = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign trial = sh - {1'b0, d_q};

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        dz_d    = dz_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
`ifdef RESTORING_DIV_SIGNED_EN
        neg_q_d = neg_q_q;
        neg_r_d = neg_r_q;
`endif
        case (state_q)
            IDLE: if (start) begin
                if (divisor == '0) begin
                    q_d     = '1;
                    r_d     = {1'b0, dividend};
                    dz_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    q_d     = a_mag;
                    d_d     = b_mag;
                    r_d     = '0;
                    cnt_d   = CW'(WIDTH);
                    dz_d    = 1'b0;
                    state_d = CALC;
`ifdef RESTORING_DIV_SIGNED_EN
                    neg_q_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    neg_r_d = dividend[WIDTH-1];
`endif
                end
            end
            CALC: begin
                r_d   = trial[WIDTH] ? sh : trial;
                q_d   = {q_q[WIDTH-2:0], ~trial[WIDTH]};
                cnt_d = cnt_q - CW'(1);
`ifdef RESTORING_DIV_SIGNED_EN
                if (cnt_q == CW'(1)) state_d = FIX;
`else
                if (cnt_q == CW'(1)) state_d = DONE;
`endif
            end
`ifdef RESTORING_DIV_SIGNED_EN
            FIX: begin
                q_d     = neg_q_q ? -q_q : q_q;
                r_d     = {1'b0, neg_r_q ? -r_q[WIDTH-1:0] : r_q[WIDTH-1:0]};
                state_d = DONE;
            end
`endif
            DONE: begin
                quot_d  = q_q;
                rem_d   = r_q[WIDTH-1:0];
                dbz_d   = dz_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            dz_q    <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
`ifdef RESTORING_DIV_SIGNED_EN
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            dz_q    <= dz_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
`ifdef RESTORING_DIV_SIGNED_EN
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
`endif
        end
    end

    // the new result is visible during the valid cycle itself, then held in the output registers
    assign ready = state_q == IDLE;
    assign valid = state_q == DONE;
    assign quot  = valid ? q_q : quot_q;
    assign rem   = valid ? r_q[WIDTH-1:0] : rem_q;
    assign dbz   = valid ? dz_q : dbz_q;
endmodule
